// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - synchronous modulo-N up/down counter with load, enable, saturate and terminal count
module updown_mod_counter #(
  parameter int     WIDTH     = 3,
  parameter longint MODULUS   = 8,
  parameter longint RESET_VAL = MODULUS - 1,
  parameter bit     SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  // MODULUS may be 2^WIDTH, so bounds are compared in 64 bits to avoid truncation.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [63:0]      MOD64 = 64'(MODULUS);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign at_top = (q == MAX_Q);
  assign at_bot = (q == '0);
  assign qbar   = ~q;
  assign tc     = en & (up_dn ? at_top : at_bot);

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = (64'(load_val) < MOD64) ? load_val : MAX_Q;
    end else if (en) begin
      if (up_dn) begin
        if (!at_top) begin
          q_next = q + WIDTH'(1);
        end else if (!SATURATE) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          q_next = q - WIDTH'(1);
        end else if (!SATURATE) begin
          q_next    = MAX_Q;
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - bench for updown_mod_counter across three parameter sets
module tb_updown_mod_counter;

  localparam int NI = 3;
  localparam int MODS [NI] = '{8, 5, 6};
  localparam int RVS  [NI] = '{7, 4, 5};
  localparam bit SATS [NI] = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] q_o    [NI];
  logic [2:0] qbar_o [NI];
  logic       tc_o   [NI];
  logic       wrap_o [NI];

  int total = 0;
  int bad = 0;
  int mq [NI];
  int mw [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    updown_mod_counter #(
      .WIDTH(3), .MODULUS(MODS[g]), .RESET_VAL(RVS[g]), .SATURATE(SATS[g])
    ) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .q(q_o[g]), .qbar(qbar_o[g]), .tc(tc_o[g]), .wrap(wrap_o[g])
    );
  end

  task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0d want=%0d", tag, g, obs, exp);
    end
  endtask

  // Reference: one clock edge of a modulo counter, straight from the counting rules.
  function automatic void model_edge(int g);
    int m = MODS[g];
    mw[g] = 0;
    if (rst) begin
      mq[g] = RVS[g];
    end else if (load) begin
      mq[g] = (int'(load_val) < m) ? int'(load_val) : m - 1;
    end else if (en) begin
      if (up_dn) begin
        if (mq[g] < m - 1) mq[g] = mq[g] + 1;
        else if (!SATS[g]) begin mq[g] = 0; mw[g] = 1; end
      end else begin
        if (mq[g] > 0) mq[g] = mq[g] - 1;
        else if (!SATS[g]) begin mq[g] = m - 1; mw[g] = 1; end
      end
    end
  endfunction

  task automatic check_outputs();
    for (int g = 0; g < NI; g++) begin
      chk("q", g, 32'(q_o[g]), 32'(mq[g]));
      chk("qbar", g, 32'(qbar_o[g]), 32'((~mq[g]) & 7));
      chk("wrap", g, 32'(wrap_o[g]), 32'(mw[g]));
    end
  endtask

  task automatic check_tc();
    for (int g = 0; g < NI; g++)
      chk("tc", g, 32'(tc_o[g]), 32'(en && (up_dn ? (mq[g] == MODS[g] - 1) : (mq[g] == 0))));
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic step();
    #1;
    check_tc();
    @(posedge clk);
    for (int g = 0; g < NI; g++) model_edge(g);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(logic e, logic u, logic l, logic [2:0] lv);
    en = e; up_dn = u; load = l; load_val = lv;
  endtask

  initial begin
    // Asynchronous reset between edges, no clock needed.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin mq[g] = RVS[g]; mw[g] = 0; end
    check_outputs();
    chk("rst_q7", 0, 32'(q_o[0]), 32'd7);
    rst = 1'b0;
    @(negedge clk);

    // Down count through the wrap.
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++) step();
    chk("down_end", 0, 32'(q_o[0]), 32'd6);

    // Up count through the modulus.
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) step();

    // Load priority and clamp.
    drive(1'b1, 1'b1, 1'b1, 3'd2); step();
    chk("load_pri", 1, 32'(q_o[1]), 32'd2);
    drive(1'b0, 1'b1, 1'b1, 3'd7); step();
    chk("clamp", 1, 32'(q_o[1]), 32'd4);
    drive(1'b0, 1'b0, 1'b1, 3'd3); step();
    chk("load_noen", 1, 32'(q_o[1]), 32'd3);

    // Direction change and enable gating from q=3.
    drive(1'b1, 1'b1, 1'b0, 3'd0); step(); step();
    drive(1'b1, 1'b0, 1'b0, 3'd0); step();
    drive(1'b0, 1'b1, 1'b0, 3'd0); step(); step();
    drive(1'b1, 1'b0, 1'b0, 3'd0); step();
    chk("dir_end", 0, 32'(q_o[0]), 32'd3);

    // Saturate: down from 1, then up from 4.
    drive(1'b0, 1'b0, 1'b1, 3'd1); step();
    drive(1'b1, 1'b0, 1'b0, 3'd0); for (int i = 0; i < 3; i++) step();
    chk("sat_lo", 2, 32'(q_o[2]), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 3'd4); step();
    drive(1'b1, 1'b1, 1'b0, 3'd0); for (int i = 0; i < 3; i++) step();
    chk("sat_hi", 2, 32'(q_o[2]), 32'd5);

    // Reset during a cycle that would wrap.
    drive(1'b0, 1'b0, 1'b1, 3'd0); step();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin mq[g] = RVS[g]; mw[g] = 0; end
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst_nowrap", 0, 32'(wrap_o[0]), 32'd0);
    rst = 1'b0;
    step();
    chk("resume", 0, 32'(q_o[0]), 32'd6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) == 0), 3'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
